ucsbece154b_evict_buffer: RTL

//  Small FIFO between the L1 data array's eviction port and the victim cache write port.

---
 rtl/ucsbece154b_evict_buffer.sv | 132 +++++++++++++
 1 files changed

// File: rtl/ucsbece154b_evict_buffer.sv
// Eviction FIFO between the L1 eviction port and the victim cache write port.
// Buffers evicted lines, drains one per cycle, forwards on lookup, coalesces repeats.
module ucsbece154b_evict_buffer #(
  parameter int unsigned ADDR_WIDTH = 56,
  parameter int unsigned LINE_WIDTH = 128,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic                         evict_valid_i,
  output logic                         evict_ready_o,
  input  logic [ADDR_WIDTH-1:0]        evict_addr_i,
  input  logic [LINE_WIDTH-1:0]        evict_data_i,
  input  logic [ADDR_WIDTH-1:0]        raddr_i,
  output logic                         fwd_hit_o,
  output logic [LINE_WIDTH-1:0]        fwd_data_o,
  input  logic                         vc_stall_i,
  output logic                         vc_we_o,
  output logic [ADDR_WIDTH-1:0]        vc_waddr_o,
  output logic [LINE_WIDTH-1:0]        vc_wdata_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         full_o,
  output logic                         empty_o
);

  localparam int unsigned OFFSET_WIDTH = $clog2(LINE_WIDTH/8);
  localparam int unsigned TAG_WIDTH    = ADDR_WIDTH - OFFSET_WIDTH;
  localparam int unsigned PTR_WIDTH    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_WIDTH    = $clog2(DEPTH+1);
  localparam logic [PTR_WIDTH-1:0] LAST_PTR  = PTR_WIDTH'(DEPTH-1);
  localparam logic [CNT_WIDTH-1:0] DEPTH_CNT = CNT_WIDTH'(DEPTH);

  logic [TAG_WIDTH-1:0]  r_tag  [DEPTH];
  logic [LINE_WIDTH-1:0] r_data [DEPTH];
  logic [DEPTH-1:0]      r_valid;
  logic [PTR_WIDTH-1:0]  r_head;
  logic [PTR_WIDTH-1:0]  r_tail;
  logic [CNT_WIDTH-1:0]  r_count;

  logic [TAG_WIDTH-1:0]  w_evict_tag;
  logic [TAG_WIDTH-1:0]  w_lookup_tag;
  logic                  w_accept;
  logic                  w_drain;
  logic                  w_alloc;
  logic                  w_coal_hit;
  logic [PTR_WIDTH-1:0]  w_coal_idx;
  logic                  w_unused;

  function automatic logic [PTR_WIDTH-1:0] f_next(input logic [PTR_WIDTH-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign w_evict_tag  = evict_addr_i[ADDR_WIDTH-1:OFFSET_WIDTH];
  assign w_lookup_tag = raddr_i[ADDR_WIDTH-1:OFFSET_WIDTH];
  assign w_unused     = ^{evict_addr_i[OFFSET_WIDTH-1:0], raddr_i[OFFSET_WIDTH-1:0]};

  assign count_o       = r_count;
  assign full_o        = (r_count == DEPTH_CNT);
  assign empty_o       = (r_count == '0);
  assign evict_ready_o = !full_o;
  assign w_accept      = evict_valid_i && evict_ready_o;
  assign w_drain       = !empty_o && !vc_stall_i;
  assign w_alloc       = w_accept && !w_coal_hit;

  assign vc_we_o    = w_drain;
  assign vc_waddr_o = {r_tag[r_head], {OFFSET_WIDTH{1'b0}}};
  assign vc_wdata_o = r_data[r_head];

  // The head being drained this cycle is excluded from coalescing so a line is
  // never modified while the victim cache is sampling it.
  always_comb begin
    w_coal_hit = 1'b0;
    w_coal_idx = '0;
    fwd_hit_o  = 1'b0;
    fwd_data_o = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (r_valid[i] && (r_tag[i] == w_evict_tag) &&
          !(w_drain && (PTR_WIDTH'(i) == r_head))) begin
        w_coal_hit = 1'b1;
        w_coal_idx = PTR_WIDTH'(i);
      end
      if (r_valid[i] && (r_tag[i] == w_lookup_tag)) begin
        fwd_hit_o  = 1'b1;
        fwd_data_o = r_data[i];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
    end else if (flush_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
    end else begin
      if (w_drain) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= f_next(r_head);
      end
      if (w_alloc) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= f_next(r_tail);
      end
      case ({w_alloc, w_drain})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage needs no reset: entries are qualified by r_valid.
  always_ff @(posedge clk_i) begin
    if (!flush_i && w_accept) begin
      if (w_coal_hit) begin
        r_data[w_coal_idx] <= evict_data_i;
      end else begin
        r_tag[r_tail]  <= w_evict_tag;
        r_data[r_tail] <= evict_data_i;
      end
    end
  end

  a_count_bound: assert property (@(posedge clk_i) disable iff (rst_i) r_count <= DEPTH_CNT);

endmodule
